// File: rtl/bcd_7seg_scan.sv
// Four-digit multiplexed common-anode 7-segment driver for packed BCD from bin_bcd.
// Latches value/sign on load, scans digits with a prescaler, blanks leading zeros and marks bad nibbles.
module bcd_7seg_scan #(
  parameter int DIV = 27000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_i,
  input  logic        neg_i,
  input  logic        load_i,
  input  logic        blank_en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [11:0]   bcd_reg;
  logic          neg_reg;
  logic [3:0]    an_reg;
  logic [6:0]    seg_reg;

  logic          presc_tick;
  logic          zero_h;
  logic          zero_t;
  logic [2:0]    blank_dig;
  logic [6:0]    digit_seg [4];

  function automatic logic [6:0] nibble_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

  assign presc_tick = (presc_reg == PRESC_LAST);

  // A nibble above 9 is non-zero here, so invalid digits are never blanked.
  assign zero_h    = (bcd_reg[11:8] == 4'd0);
  assign zero_t    = (bcd_reg[7:4] == 4'd0);
  assign blank_dig = {blank_en_i & zero_h, blank_en_i & zero_h & zero_t, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign digit_seg[gi] = blank_dig[gi] ? SEG_BLANK : nibble_seg(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  assign digit_seg[3] = neg_reg ? SEG_MINUS : SEG_BLANK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg <= '0;
      idx_reg   <= 2'd0;
      bcd_reg   <= 12'h000;
      neg_reg   <= 1'b0;
      an_reg    <= 4'b1111;
      seg_reg   <= SEG_BLANK;
    end else begin
      if (presc_tick) begin
        presc_reg <= '0;
        idx_reg   <= idx_reg + 2'd1;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
      if (load_i) begin
        bcd_reg <= bcd_i;
        neg_reg <= neg_i;
      end
      // Output reflects the pre-edge idx/latches, so it trails idx by one cycle.
      an_reg  <= ~(4'b0001 << idx_reg);
      seg_reg <= digit_seg[idx_reg];
    end
  end

  assign an_o  = an_reg;
  assign seg_o = seg_reg;
  assign dp_o  = 1'b1;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan (DIV=4): stimulus queues per-edge expectations,
// a monitor pops one per clock and compares an/seg/dp.
module tb_bcd_7seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd_i;
  logic        neg_i;
  logic        load_i;
  logic        blank_en_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  bcd_7seg_scan #(.DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_i      (bcd_i),
    .neg_i      (neg_i),
    .load_i     (load_i),
    .blank_en_i (blank_en_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per rising edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests++;
      if ({an_o, seg_o, dp_o} !== {e.an, e.seg, 1'b1}) begin
        fails++;
        $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                 e.name, an_o, seg_o, dp_o, e.an, e.seg);
      end else begin
        $display("[TB] ok %s: an=%b seg=%b", e.name, an_o, seg_o);
      end
    end
  end

  task automatic cyc(input logic [3:0] an, input logic [6:0] seg, input string name);
    exp_t e;
    e.an   = an;
    e.seg  = seg;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic reset_hold(input int n);
    rst_n  = 1'b0;
    load_i = 1'b1;
    bcd_i  = 12'h999;
    neg_i  = 1'b1;
    repeat (n) cyc(4'b1111, 7'h7F, "reset");
  endtask

  // segs = {digit3, digit2, digit1, digit0}; first_seg is what the first edge shows
  // (digit0 built from whatever was latched before the load on that edge).
  task automatic run_edges(input logic [27:0] segs, input logic [6:0] first_seg,
                           input int n, input string name);
    logic [3:0] one;
    int d;
    one = 4'b0001;
    for (int k = 1; k <= n; k++) begin
      d = ((k - 1) / 4) % 4;
      cyc(~(one << d), (k == 1) ? first_seg : segs[d*7 +: 7], $sformatf("%s e%0d", name, k));
      load_i = 1'b0;
    end
  endtask

  task automatic scan(input logic [11:0] v, input logic neg, input logic blank,
                      input logic [27:0] segs, input int n, input string name);
    reset_hold(2);
    rst_n      = 1'b1;
    bcd_i      = v;
    neg_i      = neg;
    blank_en_i = blank;
    load_i     = 1'b1;
    // After reset the latch holds 000, so the first displayed units digit is '0'.
    run_edges(segs, S0, n, name);
  endtask

  initial begin
    rst_n      = 1'b0;
    bcd_i      = 12'h000;
    neg_i      = 1'b0;
    load_i     = 1'b0;
    blank_en_i = 1'b0;

    reset_hold(3);

    scan(12'h123, 1'b0, 1'b0, {SB, S1, S2, S3}, 20, "t2_123");
    scan(12'h007, 1'b0, 1'b1, {SB, SB, SB, S7}, 16, "t3_007_blank");
    scan(12'h007, 1'b0, 1'b0, {SB, S0, S0, S7}, 16, "t3_007_noblank");
    scan(12'h000, 1'b1, 1'b1, {SM, SB, SB, S0}, 16, "t4_neg0");
    scan(12'h1A9, 1'b0, 1'b1, {SB, S1, SE, S9}, 16, "t5_1A9");
    scan(12'h100, 1'b0, 1'b1, {SB, S1, S0, S0}, 16, "b_100");
    scan(12'h050, 1'b1, 1'b1, {SM, SB, S5, S0}, 16, "b_050");

    // Load coinciding with the idx tick: new idx shows the new value.
    scan(12'h123, 1'b0, 1'b0, {SB, S1, S2, S3}, 3, "tick_a");
    load_i = 1'b1;
    bcd_i  = 12'h456;
    neg_i  = 1'b0;
    cyc(4'b1110, S3, "tick_e4");
    load_i = 1'b0;
    for (int k = 0; k < 4; k++) cyc(4'b1101, S5, "tick_d1");
    for (int k = 0; k < 4; k++) cyc(4'b1011, S4, "tick_d2");

    // Reset mid-scan at idx=2 with load asserted.
    scan(12'h123, 1'b0, 1'b0, {SB, S1, S2, S3}, 9, "t6_pre");
    rst_n  = 1'b0;
    load_i = 1'b1;
    bcd_i  = 12'h999;
    neg_i  = 1'b1;
    cyc(4'b1111, 7'h7F, "t6_midreset");
    rst_n      = 1'b1;
    load_i     = 1'b0;
    blank_en_i = 1'b0;
    run_edges({SB, S0, S0, S0}, S0, 16, "t6_post");

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
